// File: rtl/keypad_pkg.sv
// keypad_pkg: shared key codes, debounce state encoding and digit check for the keypad entry path.
package keypad_pkg;

    localparam logic [3:0] KEY_STAR = 4'd10;
    localparam logic [3:0] KEY_HASH = 4'd11;

    typedef enum logic [1:0] {
        RELEASED,
        PRESS_WAIT,
        HELD,
        RELEASE_WAIT
    } deb_state_t;

    function automatic logic is_digit(input logic [3:0] c);
        return c <= 4'd9;
    endfunction

endpackage

// File: rtl/key_debouncer.sv
// key_debouncer: samples {valid, code}, debounces it and emits one key_strobe per accepted press.
// key_code carries the sampled code and is meaningful in the cycle key_strobe is high.
module key_debouncer
    import keypad_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] code,
    input  logic       valid,
    output logic       key_strobe,
    output logic [3:0] key_code
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES);

    logic [4:0]    samp, prev;
    logic [CW-1:0] cnt;
    logic          stable;
    deb_state_t    state, state_nx;

    assign stable   = cnt == CW'(DEBOUNCE_CYCLES - 1);
    assign key_code = samp[3:0];

    // Counter saturates once stable so a long hold cannot wrap it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            samp  <= '0;
            prev  <= '0;
            cnt   <= '0;
            state <= RELEASED;
        end else begin
            samp  <= {valid, code};
            prev  <= samp;
            cnt   <= (samp != prev) ? '0 : stable ? cnt : cnt + CW'(1);
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx   = state;
        key_strobe = 1'b0;
        case (state)
            RELEASED:     if (samp[4]) state_nx = PRESS_WAIT;
            PRESS_WAIT: begin
                if (!samp[4]) state_nx = RELEASED;
                else if (stable) begin
                    state_nx   = HELD;
                    key_strobe = 1'b1;
                end
            end
            HELD:         if (!samp[4]) state_nx = RELEASE_WAIT;
            RELEASE_WAIT: state_nx = samp[4] ? HELD : stable ? RELEASED : RELEASE_WAIT;
            default:      state_nx = RELEASED;
        endcase
    end

endmodule

// File: rtl/keypad_entry_collector.sv
// keypad_entry_collector: collects debounced digits, clears on *, submits on # with status pulses.
// Optional KEYPAD_TIMEOUT_EN clears a partial entry after TIMEOUT_CYCLES cycles without a key.
module keypad_entry_collector
    import keypad_pkg::*;
#(
    parameter int CODE_LEN        = 4,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int TIMEOUT_CYCLES  = 1000000
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [3:0]                      code,
    input  logic                            valid,
    output logic                            key_strobe,
    output logic [$clog2(CODE_LEN+1)-1:0]   entry_len,
    output logic [4*CODE_LEN-1:0]           entry_code,
    output logic                            entry_done,
    output logic                            entry_error,
    output logic                            entry_cleared
);
    localparam int LW = $clog2(CODE_LEN + 1);
    localparam int BW = 4 * CODE_LEN;

    logic [3:0]    key_code;
    logic [BW-1:0] entry_buf;
    logic          full, timeout_hit;

    key_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
        .clk        (clk),
        .rst_n      (rst_n),
        .code       (code),
        .valid      (valid),
        .key_strobe (key_strobe),
        .key_code   (key_code)
    );

    assign full = entry_len == LW'(CODE_LEN);

`ifdef KEYPAD_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] tcnt;

    assign timeout_hit = (tcnt == TW'(TIMEOUT_CYCLES - 1)) && (entry_len != '0) && !key_strobe;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) tcnt <= '0;
        else tcnt <= (key_strobe || entry_len == '0 || timeout_hit) ? '0 : tcnt + TW'(1);
    end
`else
    assign timeout_hit = TIMEOUT_CYCLES < 0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            entry_buf     <= '0;
            entry_len     <= '0;
            entry_code    <= '0;
            entry_done    <= 1'b0;
            entry_error   <= 1'b0;
            entry_cleared <= 1'b0;
        end else begin
            entry_done    <= 1'b0;
            entry_error   <= 1'b0;
            entry_cleared <= 1'b0;
            if (key_strobe) begin
                if (is_digit(key_code)) begin
                    if (full) entry_error <= 1'b1;
                    else begin
                        entry_buf <= (entry_buf << 4) | BW'(key_code);
                        entry_len <= entry_len + LW'(1);
                    end
                end else if (key_code == KEY_STAR) begin
                    entry_buf     <= '0;
                    entry_len     <= '0;
                    entry_cleared <= 1'b1;
                end else if (key_code == KEY_HASH) begin
                    if (full) begin
                        entry_code <= entry_buf;
                        entry_done <= 1'b1;
                    end else entry_error <= 1'b1;
                    entry_buf <= '0;
                    entry_len <= '0;
                end
            end else if (timeout_hit) begin
                entry_buf     <= '0;
                entry_len     <= '0;
                entry_cleared <= 1'b1;
            end
        end
    end

endmodule
